button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Consumes the debounced switch level produced by the debounce stage for robotics-cape push-buttons.
- Classifies activity into single-cycle event pulses: press, release, click, double-click and long-press.
- Outputs feed the cape register block and interrupt logic.
- Input is already clean and synchronous to clk, so no extra synchronisers are required.

Parameters:
- ACTIVE_LOW, 1, 1 = button asserted when btn_in is 0; 0 = asserted when btn_in is 1.
- LONG_CYCLES, 25000000, number of held cycles, counted from press, before long_press fires. Minimum 2.
- GAP_CYCLES, 12500000, maximum released cycles after a first press for a second press to count as a double-click. Minimum 2.
- CNT_W, 25, counter width. Must satisfy 2**CNT_W > max(LONG_CYCLES, GAP_CYCLES).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- btn_in  in  1  debounced button level, synchronous to clk
- held  out  1  registered asserted level (btn_in XOR ACTIVE_LOW)
- press_pulse  out  1  one-cycle pulse on assertion edge
- release_pulse  out  1  one-cycle pulse on deassertion edge
- click  out  1  one-cycle pulse: single short press confirmed
- double_click  out  1  one-cycle pulse: two short presses within the gap window
- long_press  out  1  one-cycle pulse: button held for LONG_CYCLES

Behaviour:
- Reset:
  - Asynchronous, active-low (resetn=0).
  - All outputs 0, state IDLE, cnt 0, lvl_q 0.
  - Release is synchronous to clk.
  - Asserting resetn low mid-sequence aborts it; no pulse is emitted.
- Edge detection:
  - lvl = btn_in ^ ACTIVE_LOW; lvl_q <= lvl each clock; held <= lvl.
  - A press edge is lvl & ~lvl_q; a release edge is ~lvl & lvl_q. Both are evaluated at the same clock edge.
  - press_pulse and release_pulse are registered. Each is high for exactly one cycle, one clock after the first edge that samples the new level.
  - If the button is asserted while in reset, a press is reported after reset release, because lvl_q resets to 0.
- State machine (cnt increments by 1 per cycle in PRESS1, PRESS2 and GAP; it saturates and never wraps):
  - IDLE: press edge -> PRESS1, cnt=0.
  - PRESS1:
    - Release edge with cnt < LONG_CYCLES-1 -> GAP, cnt=0.
    - cnt == LONG_CYCLES-1 while lvl=1 -> long_press pulse, then LONG.
  - LONG: release edge -> IDLE. No click is emitted.
  - GAP:
    - Press edge with cnt < GAP_CYCLES-1 -> PRESS2, cnt=0.
    - cnt == GAP_CYCLES-1 with no press -> click pulse, then IDLE.
    - If a press edge and the timeout occur in the same cycle, the press wins: -> PRESS2, no click.
  - PRESS2:
    - Release edge before cnt reaches LONG_CYCLES-1 -> double_click pulse, then IDLE.
    - cnt reaches LONG_CYCLES-1 while held -> click pulse and long_press pulse in the same cycle, then LONG.
- Event pulse timing: click, double_click and long_press are registered. Each asserts in the cycle after the triggering transition and lasts exactly one cycle.
- Pulse combinations:
  - press_pulse and release_pulse are never high together.
  - click and long_press may be high together (PRESS2 case only).
  - double_click is never high together with click or long_press.
- Width rules: all comparisons are unsigned at CNT_W bits. Parameter constraint violations are flagged by an elaboration-time check.

Decomposition:
- Shared package button_pkg holds:
  - the state encoding (IDLE, PRESS1, LONG, GAP, PRESS2) as localparams;
  - the default LONG_CYCLES and GAP_CYCLES values for a 50 MHz clock (500 ms, 250 ms).
- One sub-module is natural: button_edge, which takes lvl and produces lvl_q, the press/release edge strobes and held. It is reused by the encoder-input logic.
- FSM and counter live in button_event.

Test Plan (bench parameters ACTIVE_LOW=1, LONG_CYCLES=8, GAP_CYCLES=5, CNT_W=4):
- Reset held low, btn_in=1 -> all outputs 0. After release and 10 idle cycles -> still no pulses.
- btn_in low for 3 cycles then high:
  - press_pulse once, release_pulse once.
  - click exactly 5 cycles after leaving PRESS1.
  - no double_click or long_press.
- btn_in low 3, high 2, low 3, high -> double_click once, one cycle after the second release edge; click never asserts.
- btn_in low for 20 cycles -> long_press once, 8 cycles after press entry; held=1 throughout; release gives release_pulse only, with no click.
- btn_in low 2, high 2, low 12 -> click and long_press asserted together in the same cycle, then LONG.
- Mid-PRESS1, resetn pulsed low for 1 cycle -> outputs cleared immediately (asynchronous). With the button still held, a fresh press_pulse follows reset release and the sequence restarts.

Source files
------------

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared state encoding and 50 MHz timing defaults for the
//               push-button event classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_LONG   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_PRESS2 = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    PRESS1 = ST_PRESS1,
    LONG   = ST_LONG,
    GAP    = ST_GAP,
    PRESS2 = ST_PRESS2
  } state_e;

  // 500 ms long-press and 250 ms double-click window at 50 MHz
  localparam int unsigned LONG_CYCLES_DEFAULT = 25_000_000;
  localparam int unsigned GAP_CYCLES_DEFAULT  = 12_500_000;

endpackage
`default_nettype wire

// File: rtl/button_edge.sv
`default_nettype none
// ============================================================================
// Module      : button_edge
// Description : Registers a clean level and produces press/release strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module button_edge (
  input  logic clk,
  input  logic resetn,
  input  logic lvl,
  output logic lvl_q,
  output logic press_edge,
  output logic release_edge
);

  logic lvl_d;

  always_comb lvl_d = lvl;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lvl_q <= 1'b0;
    else         lvl_q <= lvl_d;
  end

  assign press_edge   = lvl & ~lvl_q;
  assign release_edge = ~lvl & lvl_q;

endmodule
`default_nettype wire

// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
// Module      : button_event
// Description : Classifies a debounced button level into press, release,
//               click, double-click and long-press single-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event
  import button_pkg::*;
#(
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEFAULT,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = 25
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_in,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic click,
  output logic double_click,
  output logic long_press
);

  localparam longint unsigned CNT_SPAN  = 64'd1 << CNT_W;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  generate
    if (LONG_CYCLES < 2 || GAP_CYCLES < 2 || CNT_W < 1 || CNT_W > 62 ||
        CNT_SPAN <= 64'(LONG_CYCLES) || CNT_SPAN <= 64'(GAP_CYCLES)) begin : g_bad_params
      $error("button_event: illegal LONG_CYCLES/GAP_CYCLES/CNT_W combination");
    end
  endgenerate

  logic lvl, lvl_q, press_edge, release_edge;

  assign lvl = btn_in ^ ACTIVE_LOW;

  button_edge u_edge (
    .clk          (clk),
    .resetn       (resetn),
    .lvl          (lvl),
    .lvl_q        (lvl_q),
    .press_edge   (press_edge),
    .release_edge (release_edge)
  );

  assign held = lvl_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press_pulse_q, release_pulse_q;
  logic             click_q, click_d;
  logic             double_click_q, double_click_d;
  logic             long_press_q, long_press_d;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    click_d        = 1'b0;
    double_click_d = 1'b0;
    long_press_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (press_edge) state_d = PRESS1;
      end
      PRESS1: begin
        cnt_d = cnt_inc;
        if (lvl && cnt_q == LONG_LAST) begin
          long_press_d = 1'b1;
          state_d      = LONG;
          cnt_d        = '0;
        end else if (release_edge) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      LONG: begin
        cnt_d = '0;
        if (release_edge) state_d = IDLE;
      end
      GAP: begin
        cnt_d = cnt_inc;
        // A press arriving on the timeout cycle still counts as the second press
        if (press_edge) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          click_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      PRESS2: begin
        cnt_d = cnt_inc;
        if (lvl && cnt_q == LONG_LAST) begin
          click_d      = 1'b1;
          long_press_d = 1'b1;
          state_d      = LONG;
          cnt_d        = '0;
        end else if (release_edge) begin
          double_click_d = 1'b1;
          state_d        = IDLE;
          cnt_d          = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      click_q         <= 1'b0;
      double_click_q  <= 1'b0;
      long_press_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      press_pulse_q   <= press_edge;
      release_pulse_q <= release_edge;
      click_q         <= click_d;
      double_click_q  <= double_click_d;
      long_press_q    <= long_press_d;
    end
  end

  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign click         = click_q;
  assign double_click  = double_click_q;
  assign long_press    = long_press_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event
// Description : Directed scoreboard bench for button_event (LONG=8, GAP=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event;

  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_CLICK = 5'b00100;
  localparam logic [4:0] EV_DBL   = 5'b00010;
  localparam logic [4:0] EV_LONG  = 5'b00001;

  logic clk = 1'b0;
  logic resetn, btn_in;
  logic held, press_pulse, release_pulse, click, double_click, long_press;

  always #5 clk = ~clk;

  button_event #(
    .ACTIVE_LOW  (1'b1),
    .LONG_CYCLES (8),
    .GAP_CYCLES  (5),
    .CNT_W       (4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .btn_in        (btn_in),
    .held          (held),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .click         (click),
    .double_click  (double_click),
    .long_press    (long_press)
  );

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [4:0] obs_ev();
    return {press_pulse, release_pulse, click, double_click, long_press};
  endfunction

  task automatic expect_ev(input int at, input logic [4:0] ev);
    exp_t e;
    e.cyc = at;
    e.ev  = ev;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_sb_empty(input string tag);
    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d pending expected=0", tag, cyc, sb.size());
    end
  endtask

  // One clock: held must mirror the level sampled at this edge, events must
  // match the scoreboard entry due this cycle (or be all zero).
  task automatic step();
    logic       hexp;
    logic [4:0] eexp;
    @(posedge clk);
    hexp = resetn & ~btn_in;
    #1;
    cyc++;
    eexp = '0;
    if (sb.size() > 0 && sb[0].cyc == cyc) eexp = sb.pop_front().ev;
    check("events", obs_ev(), eexp);
    check("held", {4'b0, held}, {4'b0, hexp});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    resetn = 1'b0;
    btn_in = 1'b1;
    #2;
    check("reset_events", obs_ev(), 5'b0);
    check("reset_held", {4'b0, held}, 5'b0);
    steps(3);
    resetn = 1'b1;
    steps(10);

    // single click
    btn_in = 1'b0;
    expect_ev(cyc + 1, EV_PRESS);
    steps(3);
    btn_in = 1'b1;
    expect_ev(cyc + 1, EV_REL);
    expect_ev(cyc + 6, EV_CLICK);
    steps(12);
    check_sb_empty("click_done");

    // double click
    btn_in = 1'b0;
    expect_ev(cyc + 1, EV_PRESS);
    steps(3);
    btn_in = 1'b1;
    expect_ev(cyc + 1, EV_REL);
    steps(2);
    btn_in = 1'b0;
    expect_ev(cyc + 1, EV_PRESS);
    steps(3);
    btn_in = 1'b1;
    expect_ev(cyc + 1, EV_REL | EV_DBL);
    steps(12);
    check_sb_empty("double_done");

    // long press, release emits no click
    btn_in = 1'b0;
    expect_ev(cyc + 1, EV_PRESS);
    expect_ev(cyc + 9, EV_LONG);
    steps(20);
    btn_in = 1'b1;
    expect_ev(cyc + 1, EV_REL);
    steps(10);
    check_sb_empty("long_done");

    // short press then long second press: click and long together
    btn_in = 1'b0;
    expect_ev(cyc + 1, EV_PRESS);
    steps(2);
    btn_in = 1'b1;
    expect_ev(cyc + 1, EV_REL);
    steps(2);
    btn_in = 1'b0;
    expect_ev(cyc + 1, EV_PRESS);
    expect_ev(cyc + 9, EV_CLICK | EV_LONG);
    steps(12);
    btn_in = 1'b1;
    expect_ev(cyc + 1, EV_REL);
    steps(10);
    check_sb_empty("press2_long_done");

    // asynchronous reset in the middle of PRESS1
    btn_in = 1'b0;
    expect_ev(cyc + 1, EV_PRESS);
    steps(3);
    resetn = 1'b0;
    #1;
    check("async_reset_events", obs_ev(), 5'b0);
    check("async_reset_held", {4'b0, held}, 5'b0);
    steps(1);
    resetn = 1'b1;
    expect_ev(cyc + 1, EV_PRESS);
    expect_ev(cyc + 9, EV_LONG);
    steps(12);
    btn_in = 1'b1;
    expect_ev(cyc + 1, EV_REL);
    steps(8);
    check_sb_empty("reset_restart_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
